win_checker: RTL and testbench
==============================

WIN_CHECKER -- requirements
Module: win_checker

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: start  input  1  one-cycle request to check the current board.
REQ-004 SHALL: in_gameboard  input  42  occupancy, 1 = token; cell(r,c) = bit 7r+c, row 0 bottom, col 0 left.
REQ-005 SHALL: in_players_cells  input  42  owner per cell, 0 = Player1, 1 = Player2; meaningful only where occupied.
REQ-006 SHALL: busy  output  1  high while a scan is in progress.
REQ-007 SHALL: done  output  1  one-cycle pulse when result is valid.
REQ-008 SHALL: winner  output  2  00 none, 01 Player1, 10 Player2, 11 draw; held until next start.
REQ-009 SHALL: win_cells  output  42  mask of the four winning cells, 0 when no win.

Function
REQ-010 SHALL: FSM states IDLE, SCAN, DONE; IDLE->SCAN on start; SCAN->DONE on hit or after anchor 41; DONE->IDLE after exactly one cycle.
REQ-011 SHALL: on start in IDLE, latch both board inputs into internal copies; scan uses only the copies.
REQ-012 SHALL: start sampled at edge k -> anchor 0 evaluated in cycle k+1, anchor n in cycle k+1+n, one anchor per cycle.
REQ-013 SHALL: per anchor check four lines: horizontal (c+i), col<=3; vertical (r+i), row<=2; diag up-right (r+i,c+i), row<=2, col<=3; diag up-left (r+i,c-i), row<=2, col>=3; out-of-range lines never hit.
REQ-014 SHALL: a line hits only when all four cells are occupied and have identical owner bits.
REQ-015 SHALL: on a hit, scan stops; winner = 01 or 10 from owner bit; win_cells = that line; done high in the next cycle (anchor n hit -> done at k+2+n).
REQ-016 SHALL: multiple hits on one anchor resolve with priority horizontal, vertical, up-right, up-left.
REQ-017 SHALL: no hit after anchor 41 -> winner = 11 if latched gameboard is all ones, else 00; win_cells = 0; done at k+43.
REQ-018 SHALL: a win on a full board reports the winner, never draw.
REQ-019 SHALL: start while busy or in DONE is ignored; board input changes during a scan have no effect.
REQ-020 SHALL: busy high from cycle k+1 through the final SCAN cycle; busy and done never high together.
REQ-021 SHALL: winner and win_cells clear to 0 in the cycle after an accepted start.

Reset
REQ-022 SHALL: reset forces IDLE, anchor counter 0, busy 0, done 0, winner 00, win_cells 0, latched board 0.
REQ-023 SHALL: reset during SCAN or DONE aborts with no done pulse; reset has priority over start in the same cycle.

Structure
REQ-024 SHALL: shared package connect4_pkg holds ROWS=6, COLS=7, CELLS=42, WIN_LEN=4, winner encodings, and FSM state encoding for use by column selector and turn logic.
REQ-025 SHALL: one combinational sub-module win_line_check takes the latched boards and anchor index and returns hit flags, owner, and 42-bit line mask per direction.
REQ-026 SHALL: anchor counter is 6 bits, saturating at 41; decode of row/col by constant division by 7.

Verification
REQ-027 SHALL: bits 0-3 occupied, owner 0, start at k -> done at k+2, winner=01, win_cells bits 0-3.
REQ-028 SHALL: bits 6,13,20,27 occupied, owner 1 -> done at k+8, winner=10, win_cells those bits.
REQ-029 SHALL: bits 3,9,15,21 occupied owner 0 (up-left diagonal) -> done at k+5, winner=01, win_cells those bits.
REQ-030 SHALL: bits 0-3 occupied, owners 0,0,0,1, rest empty -> done at k+43, winner=00, win_cells=0.
REQ-031 SHALL: full board, owner(r,c) = ((c div 2)+r) mod 2 -> done at k+43, winner=11.
REQ-032 SHALL: reset at k+10 of a no-win scan -> no done, outputs 0; extra start at k+5 -> ignored, single done at k+43.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared Connect-4 constants, winner codes and scan FSM encoding.
package connect4_pkg;

    localparam int unsigned ROWS    = 6;
    localparam int unsigned COLS    = 7;
    localparam int unsigned CELLS   = 42;
    localparam int unsigned WIN_LEN = 4;
    localparam int unsigned AW      = 6;
    localparam int unsigned NDIR    = 4;

    localparam logic [AW-1:0] LAST_ANCHOR = AW'(CELLS - 1);

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic winner_e owner_to_winner(input logic owner);
        return owner ? WIN_P2 : WIN_P1;
    endfunction

endpackage

// File: rtl/win_line_check.sv
// Evaluates the four candidate lines (H, V, up-right, up-left) starting at one anchor cell.
module win_line_check
    import connect4_pkg::*;
(
    input  logic [CELLS-1:0]            board_i,
    input  logic [CELLS-1:0]            owner_i,
    input  logic [AW-1:0]               anchor_i,
    output logic [NDIR-1:0]             hit_o,
    output logic [NDIR-1:0]             owner_o,
    output logic [NDIR-1:0][CELLS-1:0]  mask_o
);

    localparam int MAX_START_ROW = int'(ROWS) - int'(WIN_LEN);
    localparam int MAX_START_COL = int'(COLS) - int'(WIN_LEN);
    localparam int MIN_UL_COL    = int'(WIN_LEN) - 1;

    int            row;
    int            col;
    int            dr;
    int            dc;
    logic          in_range;
    logic          all_occ;
    logic          same;
    logic          first;
    logic [AW-1:0] idx;

    always_comb begin
        row      = int'(anchor_i) / int'(COLS);
        col      = int'(anchor_i) % int'(COLS);
        dr       = 0;
        dc       = 0;
        in_range = 1'b0;
        all_occ  = 1'b0;
        same     = 1'b0;
        first    = 1'b0;
        idx      = '0;
        hit_o    = '0;
        owner_o  = '0;
        mask_o   = '0;
        for (int d = 0; d < int'(NDIR); d++) begin
            case (d)
                0: begin
                    dr = 0; dc = 1;
                    in_range = (col <= MAX_START_COL);
                end
                1: begin
                    dr = 1; dc = 0;
                    in_range = (row <= MAX_START_ROW);
                end
                2: begin
                    dr = 1; dc = 1;
                    in_range = (row <= MAX_START_ROW) && (col <= MAX_START_COL);
                end
                default: begin
                    dr = 1; dc = -1;
                    in_range = (row <= MAX_START_ROW) && (col >= MIN_UL_COL);
                end
            endcase
            // Out-of-range lines would wrap across rows, so they are never evaluated.
            if (in_range) begin
                all_occ = 1'b1;
                same    = 1'b1;
                first   = owner_i[AW'(row * int'(COLS) + col)];
                for (int i = 0; i < int'(WIN_LEN); i++) begin
                    idx = AW'((row + dr * i) * int'(COLS) + (col + dc * i));
                    mask_o[d][idx] = 1'b1;
                    all_occ = all_occ & board_i[idx];
                    same    = same & (owner_i[idx] == first);
                end
                hit_o[d]   = all_occ & same;
                owner_o[d] = first;
            end
        end
    end

endmodule

// File: rtl/win_checker.sv
// Sequential four-in-a-row scanner: one anchor cell per cycle over a latched board snapshot.
module win_checker
    import connect4_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CELLS-1:0] in_gameboard,
    input  logic [CELLS-1:0] in_players_cells,
    output logic             busy,
    output logic             done,
    output logic [1:0]       winner,
    output logic [CELLS-1:0] win_cells
);

    state_e           state_q, state_d;
    logic [AW-1:0]    anchor_q, anchor_d;
    logic [CELLS-1:0] board_q, board_d;
    logic [CELLS-1:0] owner_q, owner_d;
    logic [CELLS-1:0] win_cells_q, win_cells_d;
    winner_e          winner_q, winner_d;

    logic [NDIR-1:0]            line_hit;
    logic [NDIR-1:0]            line_owner;
    logic [NDIR-1:0][CELLS-1:0] line_mask;
    logic                       any_hit;
    logic                       at_last;
    logic                       sel_owner;
    logic [CELLS-1:0]           sel_mask;

    win_line_check u_line_check (
        .board_i  (board_q),
        .owner_i  (owner_q),
        .anchor_i (anchor_q),
        .hit_o    (line_hit),
        .owner_o  (line_owner),
        .mask_o   (line_mask)
    );

    assign any_hit = |line_hit;
    assign at_last = (anchor_q == LAST_ANCHOR);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_SCAN;
            ST_SCAN: if (any_hit || at_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Fixed direction priority when one anchor completes several lines
    always_comb begin
        sel_owner = 1'b0;
        sel_mask  = '0;
        if (line_hit[0]) begin
            sel_owner = line_owner[0];
            sel_mask  = line_mask[0];
        end else if (line_hit[1]) begin
            sel_owner = line_owner[1];
            sel_mask  = line_mask[1];
        end else if (line_hit[2]) begin
            sel_owner = line_owner[2];
            sel_mask  = line_mask[2];
        end else if (line_hit[3]) begin
            sel_owner = line_owner[3];
            sel_mask  = line_mask[3];
        end
    end

    // Datapath next values: snapshot on accept, result capture at end of scan
    always_comb begin
        anchor_d    = anchor_q;
        board_d     = board_q;
        owner_d     = owner_q;
        winner_d    = winner_q;
        win_cells_d = win_cells_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    board_d     = in_gameboard;
                    owner_d     = in_players_cells;
                    anchor_d    = '0;
                    winner_d    = WIN_NONE;
                    win_cells_d = '0;
                end
            end
            ST_SCAN: begin
                if (any_hit) begin
                    winner_d    = owner_to_winner(sel_owner);
                    win_cells_d = sel_mask;
                end else if (at_last) begin
                    winner_d    = (&board_q) ? WIN_DRAW : WIN_NONE;
                    win_cells_d = '0;
                end else begin
                    anchor_d = anchor_q + AW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            anchor_q    <= '0;
            board_q     <= '0;
            owner_q     <= '0;
            winner_q    <= WIN_NONE;
            win_cells_q <= '0;
        end else begin
            anchor_q    <= anchor_d;
            board_q     <= board_d;
            owner_q     <= owner_d;
            winner_q    <= winner_d;
            win_cells_q <= win_cells_d;
        end
    end

    // Output decode from registered state and result
    always_comb begin
        busy      = (state_q == ST_SCAN);
        done      = (state_q == ST_DONE);
        winner    = winner_q;
        win_cells = win_cells_q;
    end

endmodule

// File: tb/tb_win_checker.sv
// Self-checking bench for win_checker: directed cases, randomized boards, reset abort, ignored starts.
module tb_win_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [41:0] gb;
    logic [41:0] pc;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic [41:0] win_cells;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    win_checker dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .in_gameboard     (gb),
        .in_players_cells (pc),
        .busy             (busy),
        .done             (done),
        .winner           (winner),
        .win_cells        (win_cells)
    );

    // Reference: first anchor (row-major) whose line of four lies on the board and is uniformly owned.
    function automatic void model(input logic [41:0] b, input logic [41:0] o,
                                  output int lat, output logic [1:0] w, output logic [41:0] m);
        int drs[4] = '{0, 1, 1, 1};
        int dcs[4] = '{1, 0, 1, -1};
        lat = 43;
        m   = '0;
        w   = (&b) ? 2'b11 : 2'b00;
        for (int a = 0; a < 42; a++) begin
            for (int d = 0; d < 4; d++) begin
                int r, c, er, ec, x;
                bit ok;
                logic [41:0] lm;
                r  = a / 7;
                c  = a % 7;
                er = r + 3 * drs[d];
                ec = c + 3 * dcs[d];
                if (er >= 6 || ec < 0 || ec > 6) continue;
                ok = 1'b1;
                lm = '0;
                for (int i = 0; i < 4; i++) begin
                    x = (r + i * drs[d]) * 7 + c + i * dcs[d];
                    lm[x[5:0]] = 1'b1;
                    if (!b[x[5:0]] || (o[x[5:0]] !== o[a[5:0]])) ok = 1'b0;
                end
                if (ok) begin
                    lat = a + 2;
                    w   = o[a[5:0]] ? 2'b10 : 2'b01;
                    m   = lm;
                    return;
                end
            end
        end
    endfunction

    // Drives one scan from IDLE and reports what the DUT did; comparisons live in the callers.
    task automatic do_scan(input logic [41:0] b, input logic [41:0] o, input bit mutate,
                           output int lat, output logic [1:0] w, output logic [41:0] m,
                           output bit cleared, output bit overlap, output bit held);
        lat = -1; w = 2'b00; m = '0; cleared = 1'b0; overlap = 1'b0; held = 1'b0;
        gb = b; pc = o; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cleared = busy && !done && (winner == 2'b00) && (win_cells == '0);
        for (int j = 1; j <= 60; j++) begin
            if (busy && done) overlap = 1'b1;
            if (done) begin
                lat = j; w = winner; m = win_cells;
                break;
            end
            if (mutate) begin
                gb    = 42'({$urandom(), $urandom()});
                pc    = 42'({$urandom(), $urandom()});
                start = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
        held = !done && !busy && (winner == w) && (win_cells == m);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; gb = '1; pc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        chk_cnt++; if (winner !== 2'b00) $display("FAIL reset_winner got=%b exp=00", winner); else pass_cnt++;
        chk_cnt++; if (win_cells !== '0) $display("FAIL reset_win_cells got=%h exp=0", win_cells); else pass_cnt++;
        // Reset wins over a simultaneous start
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_over_start busy=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [41:0] bs[5];
        logic [41:0] os[5];
        int          exp_lat[5] = '{2, 8, 5, 43, 43};
        logic [1:0]  exp_w[5]   = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b11};
        logic [41:0] exp_m[5];
        int lat; logic [1:0] w; logic [41:0] m; bit cl, ov, hd;
        bs[0] = 42'h00F; os[0] = '0; exp_m[0] = 42'h00F;
        bs[1] = '0; bs[1][6] = 1; bs[1][13] = 1; bs[1][20] = 1; bs[1][27] = 1;
        os[1] = bs[1]; exp_m[1] = bs[1];
        bs[2] = '0; bs[2][3] = 1; bs[2][9] = 1; bs[2][15] = 1; bs[2][21] = 1;
        os[2] = '0; exp_m[2] = bs[2];
        bs[3] = 42'h00F; os[3] = 42'h008; exp_m[3] = '0;
        bs[4] = '1; os[4] = '0; exp_m[4] = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                os[4][r * 7 + c] = 1'(((c / 2) + r) % 2);
        for (int t = 0; t < 5; t++) begin
            do_scan(bs[t], os[t], 1'b0, lat, w, m, cl, ov, hd);
            chk_cnt++; if (lat !== exp_lat[t]) $display("FAIL dir%0d_latency got=%0d exp=%0d", t, lat, exp_lat[t]); else pass_cnt++;
            chk_cnt++; if (w !== exp_w[t]) $display("FAIL dir%0d_winner got=%b exp=%b", t, w, exp_w[t]); else pass_cnt++;
            chk_cnt++; if (m !== exp_m[t]) $display("FAIL dir%0d_win_cells got=%h exp=%h", t, m, exp_m[t]); else pass_cnt++;
            chk_cnt++; if (!cl || ov || !hd) $display("FAIL dir%0d_handshake cleared=%b overlap=%b held=%b exp=1,0,1", t, cl, ov, hd); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [41:0] b, o, em; logic [1:0] ew; int el;
        int lat; logic [1:0] w; logic [41:0] m; bit cl, ov, hd;
        for (int t = 0; t < 40; t++) begin
            o = 42'({$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) begin
                b = '1;
            end else begin
                for (int i = 0; i < 42; i++) b[i] = ($urandom_range(0, 9) < 7);
            end
            model(b, o, el, ew, em);
            do_scan(b, o, 1'b1, lat, w, m, cl, ov, hd);
            chk_cnt++;
            if (lat !== el || w !== ew || m !== em || !cl || ov || !hd)
                $display("FAIL rand%0d got lat=%0d w=%b m=%h cl=%b ov=%b hd=%b exp lat=%0d w=%b m=%h cl=1 ov=0 hd=1",
                         t, lat, w, m, cl, ov, hd, el, ew, em);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done = 1'b0;
        bit was_busy;
        gb = 42'h00F; pc = 42'h008; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        was_busy = busy;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_cnt++; if (!was_busy) $display("FAIL abort_busy_before got=%b exp=1", was_busy); else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || winner !== 2'b00 || win_cells !== '0)
            $display("FAIL abort_outputs busy=%b done=%b winner=%b cells=%h exp=0,0,00,0", busy, done, winner, win_cells);
        else pass_cnt++;
        repeat (50) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk_cnt++; if (saw_done) $display("FAIL abort_no_done got=1 exp=0"); else pass_cnt++;
    endtask

    task automatic test_ignored_start();
        int n_done = 0;
        int first  = -1;
        logic [1:0] w = 2'b11;
        gb = 42'h00F; pc = 42'h008; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 1; j <= 70; j++) begin
            if (j == 5) begin
                gb = 42'h00F; pc = '0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                if (first < 0) begin first = j; w = winner; end
            end
            @(posedge clk); #1;
        end
        chk_cnt++; if (n_done !== 1) $display("FAIL ignored_start_count got=%0d exp=1", n_done); else pass_cnt++;
        chk_cnt++; if (first !== 43) $display("FAIL ignored_start_latency got=%0d exp=43", first); else pass_cnt++;
        chk_cnt++; if (w !== 2'b00) $display("FAIL ignored_start_winner got=%b exp=00", w); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; gb = '0; pc = '0;
        test_reset();
        test_directed();
        test_random();
        test_reset_abort();
        test_ignored_start();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
